// File: rtl/coprocessor0_pkg.sv
// ============================================================================
//  Module      : coprocessor0_pkg
//  Description : CP0 register map, ExcCodes, PRID and status/cause bit fields.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package coprocessor0_pkg;

   localparam int CP0_REG_BUS = 5;
   localparam int DATA_BUS    = 32;

   localparam logic [CP0_REG_BUS-1:0] C_REG_COUNT   = 5'd9;
   localparam logic [CP0_REG_BUS-1:0] C_REG_COMPARE = 5'd11;
   localparam logic [CP0_REG_BUS-1:0] C_REG_STATUS  = 5'd12;
   localparam logic [CP0_REG_BUS-1:0] C_REG_CAUSE   = 5'd13;
   localparam logic [CP0_REG_BUS-1:0] C_REG_EPC     = 5'd14;
   localparam logic [CP0_REG_BUS-1:0] C_REG_PRID    = 5'd15;

   typedef enum logic [4:0] {
      EXC_INT  = 5'd0,
      EXC_MOD  = 5'd1,
      EXC_TLBL = 5'd2,
      EXC_TLBS = 5'd3,
      EXC_ADEL = 5'd4,
      EXC_ADES = 5'd5,
      EXC_IBE  = 5'd6,
      EXC_DBE  = 5'd7,
      EXC_SYS  = 5'd8,
      EXC_BP   = 5'd9,
      EXC_RI   = 5'd10,
      EXC_CPU  = 5'd11,
      EXC_OV   = 5'd12,
      EXC_TR   = 5'd13
   } exc_code_e;

   localparam int C_STATUS_IE    = 0;
   localparam int C_STATUS_EXL   = 1;
   localparam int C_STATUS_IM_LO = 8;
   localparam int C_STATUS_IM_HI = 15;

   localparam int C_CAUSE_EXC_LO = 2;
   localparam int C_CAUSE_EXC_HI = 6;
   localparam int C_CAUSE_SW_LO  = 8;
   localparam int C_CAUSE_SW_HI  = 9;
   localparam int C_CAUSE_IP_LO  = 10;
   localparam int C_CAUSE_IP_HI  = 15;
   localparam int C_CAUSE_BD     = 31;

   localparam logic [DATA_BUS-1:0] C_PRID_VALUE   = 32'h0000_4220;
   localparam logic [DATA_BUS-1:0] C_STATUS_RESET = 32'h1000_0000;

   // Software-writable masks built from the field positions above.
   localparam logic [DATA_BUS-1:0] C_STATUS_WMASK =
      ((32'h1 << (C_STATUS_IM_HI + 1)) - (32'h1 << C_STATUS_IM_LO))
      | (32'h1 << C_STATUS_EXL) | (32'h1 << C_STATUS_IE);
   localparam logic [DATA_BUS-1:0] C_CAUSE_WMASK =
      (32'h1 << (C_CAUSE_SW_HI + 1)) - (32'h1 << C_CAUSE_SW_LO);

endpackage

`default_nettype wire

// File: rtl/coprocessor0_if.sv
// ============================================================================
//  Module      : coprocessor0_if
//  Description : Pipeline <-> CP0 bus: MTC0/MFC0, exception/ERET commit, state.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface coprocessor0_if
   import coprocessor0_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_BUS
);

   logic                   we;
   logic [CP0_REG_BUS-1:0] waddr;
   logic [DATA_WIDTH-1:0]  wdata;
   logic [CP0_REG_BUS-1:0] raddr;
   logic [DATA_WIDTH-1:0]  rdata;
   logic [5:0]             int_i;
   logic                   exc_valid;
   logic [4:0]             exc_code;
   logic [DATA_WIDTH-1:0]  exc_pc;
   logic                   exc_in_delay_slot;
   logic                   eret;
   logic [DATA_WIDTH-1:0]  status;
   logic [DATA_WIDTH-1:0]  cause;
   logic [DATA_WIDTH-1:0]  epc;
   logic [DATA_WIDTH-1:0]  count;
   logic [DATA_WIDTH-1:0]  compare;
   logic                   timer_int;

   modport master (
      output we, waddr, wdata, raddr, int_i,
      output exc_valid, exc_code, exc_pc, exc_in_delay_slot, eret,
      input  rdata, status, cause, epc, count, compare, timer_int
   );

   modport slave (
      input  we, waddr, wdata, raddr, int_i,
      input  exc_valid, exc_code, exc_pc, exc_in_delay_slot, eret,
      output rdata, status, cause, epc, count, compare, timer_int
   );

endinterface

`default_nettype wire

// File: rtl/cp0_timer.sv
// ============================================================================
//  Module      : cp0_timer
//  Description : Free-running COUNT, COMPARE and the sticky timer interrupt.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cp0_timer #(
   parameter int DATA_WIDTH = 32
) (
   input  wire logic                  clk,
   input  wire logic                  rst_n,
   input  wire logic                  count_we,
   input  wire logic                  compare_we,
   input  wire logic [DATA_WIDTH-1:0] wdata,
   output logic      [DATA_WIDTH-1:0] count,
   output logic      [DATA_WIDTH-1:0] compare,
   output logic                       timer_int
);

   logic [DATA_WIDTH-1:0] r_count;
   logic [DATA_WIDTH-1:0] r_compare;
   logic                  r_timer_int;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_count     <= '0;
         r_compare   <= '0;
         r_timer_int <= 1'b0;
      end else begin
         r_count <= count_we ? wdata : r_count + DATA_WIDTH'(1);
         // Writing COMPARE acknowledges the interrupt; a zero COMPARE never fires.
         if (compare_we) begin
            r_compare   <= wdata;
            r_timer_int <= 1'b0;
         end else if ((r_count == r_compare) && (r_compare != '0)) begin
            r_timer_int <= 1'b1;
         end
      end
   end

   assign count     = r_count;
   assign compare   = r_compare;
   assign timer_int = r_timer_int;

endmodule

`default_nettype wire

// File: rtl/coprocessor0.sv
// ============================================================================
//  Module      : coprocessor0
//  Description : MIPS CP0 - STATUS/CAUSE/EPC/PRID, exception entry/ERET, timer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module coprocessor0
   import coprocessor0_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_BUS
) (
   input  wire logic      clk,
   input  wire logic      rst_n,
   coprocessor0_if.slave  bus
);

   localparam logic [DATA_WIDTH-1:0] C_STATUS_RST = DATA_WIDTH'(C_STATUS_RESET);
   localparam logic [DATA_WIDTH-1:0] C_STATUS_WM  = DATA_WIDTH'(C_STATUS_WMASK);
   localparam logic [DATA_WIDTH-1:0] C_CAUSE_WM   = DATA_WIDTH'(C_CAUSE_WMASK);
   localparam logic [DATA_WIDTH-1:0] C_PRID       = DATA_WIDTH'(C_PRID_VALUE);

   logic [DATA_WIDTH-1:0] r_status;
   logic [DATA_WIDTH-1:0] r_cause;
   logic [DATA_WIDTH-1:0] r_epc;

   logic [DATA_WIDTH-1:0] w_status_sw;
   logic [DATA_WIDTH-1:0] w_cause_sw;
   logic [DATA_WIDTH-1:0] w_status_nxt;
   logic [DATA_WIDTH-1:0] w_cause_nxt;
   logic [DATA_WIDTH-1:0] w_epc_nxt;
   logic [DATA_WIDTH-1:0] w_rdata;
   logic [DATA_WIDTH-1:0] w_count;
   logic [DATA_WIDTH-1:0] w_compare;
   logic                  w_timer_int;
   logic [5:0]            w_cause_ip;
   logic                  w_wr_count;
   logic                  w_wr_compare;
   logic                  w_wr_status;
   logic                  w_wr_cause;
   logic                  w_wr_epc;
   logic                  w_bypass;

   assign w_wr_count   = bus.we && (bus.waddr == C_REG_COUNT);
   assign w_wr_compare = bus.we && (bus.waddr == C_REG_COMPARE);
   assign w_wr_status  = bus.we && (bus.waddr == C_REG_STATUS);
   assign w_wr_cause   = bus.we && (bus.waddr == C_REG_CAUSE);
   assign w_wr_epc     = bus.we && (bus.waddr == C_REG_EPC);
   assign w_bypass     = bus.we && (bus.waddr == bus.raddr);

   assign w_status_sw = (r_status & ~C_STATUS_WM) | (bus.wdata & C_STATUS_WM);
   assign w_cause_sw  = (r_cause  & ~C_CAUSE_WM)  | (bus.wdata & C_CAUSE_WM);
   assign w_cause_ip  = {w_timer_int | bus.int_i[5], bus.int_i[4:0]};

   cp0_timer #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .count_we   (w_wr_count),
      .compare_we (w_wr_compare),
      .wdata      (bus.wdata),
      .count      (w_count),
      .compare    (w_compare),
      .timer_int  (w_timer_int)
   );

   // Software write forms the base; exception then ERET overlay the fields they own.
   always_comb begin
      w_status_nxt = w_wr_status ? w_status_sw : r_status;
      w_cause_nxt  = w_wr_cause  ? w_cause_sw  : r_cause;
      w_epc_nxt    = w_wr_epc    ? bus.wdata   : r_epc;
      w_cause_nxt[C_CAUSE_IP_HI:C_CAUSE_IP_LO] = w_cause_ip;
      if (bus.exc_valid) begin
         w_cause_nxt[C_CAUSE_EXC_HI:C_CAUSE_EXC_LO] = bus.exc_code;
         w_status_nxt[C_STATUS_EXL]                 = 1'b1;
         if (!r_status[C_STATUS_EXL]) begin
            w_epc_nxt = bus.exc_in_delay_slot ? (bus.exc_pc - DATA_WIDTH'(4))
                                              : bus.exc_pc;
            w_cause_nxt[C_CAUSE_BD] = bus.exc_in_delay_slot;
         end else begin
            // Nested exception: keep the original return context.
            w_epc_nxt               = r_epc;
            w_cause_nxt[C_CAUSE_BD] = r_cause[C_CAUSE_BD];
         end
      end else if (bus.eret) begin
         w_status_nxt[C_STATUS_EXL] = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_status <= C_STATUS_RST;
         r_cause  <= '0;
         r_epc    <= '0;
      end else begin
         r_status <= w_status_nxt;
         r_cause  <= w_cause_nxt;
         r_epc    <= w_epc_nxt;
      end
   end

   always_comb begin
      w_rdata = '0;
      case (bus.raddr)
         C_REG_COUNT:   w_rdata = w_bypass ? bus.wdata   : w_count;
         C_REG_COMPARE: w_rdata = w_bypass ? bus.wdata   : w_compare;
         C_REG_STATUS:  w_rdata = w_bypass ? w_status_sw : r_status;
         C_REG_CAUSE:   w_rdata = w_bypass ? w_cause_sw  : r_cause;
         C_REG_EPC:     w_rdata = w_bypass ? bus.wdata   : r_epc;
         C_REG_PRID:    w_rdata = C_PRID;
         default:       w_rdata = '0;
      endcase
   end

   assign bus.rdata     = w_rdata;
   assign bus.status    = r_status;
   assign bus.cause     = r_cause;
   assign bus.epc       = r_epc;
   assign bus.count     = w_count;
   assign bus.compare   = w_compare;
   assign bus.timer_int = w_timer_int;

endmodule

`default_nettype wire

// File: tb/tb_coprocessor0.sv
// ============================================================================
//  Module      : tb_coprocessor0
//  Description : Directed vector bench for coprocessor0.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_coprocessor0;
   import coprocessor0_pkg::*;

   logic clk;
   logic rst_n;
   int   n_pass;
   int   n_total;

   coprocessor0_if #(.DATA_WIDTH(32)) bus ();

   coprocessor0 #(
      .DATA_WIDTH (32)
   ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic [4:0]  raddr;
      logic [5:0]  int_i;
      logic        exc_valid;
      logic [4:0]  exc_code;
      logic [31:0] exc_pc;
      logic        dslot;
      logic        eret;
      logic [31:0] exp_rdata;
      logic [31:0] exp_status;
      logic [31:0] exp_cause;
      logic [31:0] exp_epc;
   } vec_t;

   vec_t vecs [12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp)
         $display("FAIL %s: got %h expected %h", name, act, exp);
      else
         n_pass++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.we = 1'b0; bus.waddr = '0; bus.wdata = '0; bus.raddr = '0;
      bus.int_i = '0; bus.exc_valid = 1'b0; bus.exc_code = '0;
      bus.exc_pc = '0; bus.exc_in_delay_slot = 1'b0; bus.eret = 1'b0;
   endtask

   task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
      bus.we = 1'b1; bus.waddr = a; bus.wdata = d;
   endtask

   initial begin
      n_pass  = 0;
      n_total = 0;

      //             we    waddr          wdata         raddr         int_i  exc   code   exc_pc        ds    eret  rdata         status        cause         epc
      vecs[0]  = '{1'b0, 5'd0,          32'h0,        C_REG_STATUS, 6'h00, 1'b1, 5'd12, 32'h00400010, 1'b1, 1'b0, 32'h10000000, 32'h10000002, 32'h80000030, 32'h0040000C};
      vecs[1]  = '{1'b0, 5'd0,          32'h0,        C_REG_EPC,    6'h00, 1'b1, 5'd4,  32'h00400100, 1'b0, 1'b0, 32'h0040000C, 32'h10000002, 32'h80000010, 32'h0040000C};
      vecs[2]  = '{1'b0, 5'd0,          32'h0,        C_REG_CAUSE,  6'h00, 1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 32'h80000010, 32'h10000000, 32'h80000010, 32'h0040000C};
      vecs[3]  = '{1'b1, C_REG_STATUS,  32'hFFFFFFFF, C_REG_STATUS, 6'h00, 1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 32'h1000FF03, 32'h1000FF03, 32'h80000010, 32'h0040000C};
      vecs[4]  = '{1'b1, C_REG_CAUSE,   32'hFFFFFFFF, C_REG_CAUSE,  6'h00, 1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 32'h80000310, 32'h1000FF03, 32'h80000310, 32'h0040000C};
      vecs[5]  = '{1'b0, 5'd0,          32'h0,        C_REG_PRID,   6'h25, 1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 32'h00004220, 32'h1000FF03, 32'h80009710, 32'h0040000C};
      vecs[6]  = '{1'b1, C_REG_EPC,     32'hABCD0000, C_REG_EPC,    6'h00, 1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 32'hABCD0000, 32'h1000FF03, 32'h80000310, 32'hABCD0000};
      vecs[7]  = '{1'b1, C_REG_STATUS,  32'hFFFFFFFF, C_REG_EPC,    6'h00, 1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 32'hABCD0000, 32'h1000FF01, 32'h80000310, 32'hABCD0000};
      vecs[8]  = '{1'b1, C_REG_EPC,     32'h00001234, 5'd3,         6'h00, 1'b1, 5'd0,  32'h00000080, 1'b0, 1'b0, 32'h00000000, 32'h1000FF03, 32'h00000300, 32'h00000080};
      vecs[9]  = '{1'b1, 5'd3,          32'hFFFFFFFF, 5'd3,         6'h00, 1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 32'h00000000, 32'h1000FF03, 32'h00000300, 32'h00000080};
      vecs[10] = '{1'b1, C_REG_EPC,     32'h00000055, C_REG_STATUS, 6'h00, 1'b1, 5'd8,  32'h00000200, 1'b1, 1'b0, 32'h1000FF03, 32'h1000FF03, 32'h00000320, 32'h00000080};
      vecs[11] = '{1'b1, C_REG_STATUS,  32'h00000000, C_REG_CAUSE,  6'h00, 1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 32'h00000320, 32'h10000000, 32'h00000320, 32'h00000080};

      // Reset must win over a simultaneous exception and write.
      idle_inputs();
      rst_n = 1'b0;
      write_reg(C_REG_STATUS, 32'hFFFFFFFF);
      bus.exc_valid = 1'b1; bus.exc_code = 5'd12; bus.exc_pc = 32'h400;
      tick();
      tick();
      chk("rst_status",  bus.status,  32'h10000000);
      chk("rst_cause",   bus.cause,   32'h0);
      chk("rst_epc",     bus.epc,     32'h0);
      chk("rst_count",   bus.count,   32'h0);
      chk("rst_compare", bus.compare, 32'h0);
      chk("rst_timer",   {31'd0, bus.timer_int}, 32'h0);

      idle_inputs();
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      chk("idle_count",  bus.count,  32'd5);
      chk("idle_status", bus.status, 32'h10000000);
      chk("idle_cause",  bus.cause,  32'h0);
      chk("idle_timer",  {31'd0, bus.timer_int}, 32'h0);

      // Timer: arm at count 10, fire the cycle after count reaches 20.
      for (int i = 0; i < 5; i++) tick();
      chk("count_at_10", bus.count, 32'd10);
      write_reg(C_REG_COMPARE, 32'd20);
      tick();
      bus.we = 1'b0;
      chk("compare_20", bus.compare, 32'd20);
      for (int i = 0; i < 9; i++) tick();
      chk("count_at_20", bus.count, 32'd20);
      chk("timer_not_yet", {31'd0, bus.timer_int}, 32'h0);
      tick();
      chk("timer_fire", {31'd0, bus.timer_int}, 32'h1);
      tick();
      chk("timer_sticky", {31'd0, bus.timer_int}, 32'h1);
      chk("cause_ip7",    bus.cause, 32'h00008000);
      write_reg(C_REG_COMPARE, 32'd40);
      tick();
      chk("timer_clear", {31'd0, bus.timer_int}, 32'h0);
      chk("compare_40",  bus.compare, 32'd40);
      write_reg(C_REG_COMPARE, 32'd0);
      tick();
      bus.we = 1'b0;
      chk("cause_ip7_clr", bus.cause, 32'h0);

      for (int i = 0; i < 12; i++) begin
         bus.we = vecs[i].we; bus.waddr = vecs[i].waddr; bus.wdata = vecs[i].wdata;
         bus.raddr = vecs[i].raddr; bus.int_i = vecs[i].int_i;
         bus.exc_valid = vecs[i].exc_valid; bus.exc_code = vecs[i].exc_code;
         bus.exc_pc = vecs[i].exc_pc; bus.exc_in_delay_slot = vecs[i].dslot;
         bus.eret = vecs[i].eret;
         #1;
         chk($sformatf("v%0d_rdata", i), bus.rdata, vecs[i].exp_rdata);
         tick();
         chk($sformatf("v%0d_status", i), bus.status, vecs[i].exp_status);
         chk($sformatf("v%0d_cause", i),  bus.cause,  vecs[i].exp_cause);
         chk($sformatf("v%0d_epc", i),    bus.epc,    vecs[i].exp_epc);
      end
      idle_inputs();

      // COUNT load with read bypass, then increment and wrap.
      write_reg(C_REG_COUNT, 32'h100);
      bus.raddr = C_REG_COUNT;
      #1;
      chk("count_bypass", bus.rdata, 32'h100);
      tick();
      chk("count_load", bus.count, 32'h100);
      bus.we = 1'b0;
      tick();
      chk("count_inc", bus.count, 32'h101);
      write_reg(C_REG_COUNT, 32'hFFFFFFFF);
      tick();
      bus.we = 1'b0;
      chk("count_max", bus.count, 32'hFFFFFFFF);
      tick();
      chk("count_wrap", bus.count, 32'h0);
      chk("timer_off",  {31'd0, bus.timer_int}, 32'h0);

      // Reset landing on an exception commit leaves only reset values.
      write_reg(C_REG_STATUS, 32'hFFFFFFFF);
      bus.exc_valid = 1'b1; bus.exc_code = 5'd12; bus.exc_pc = 32'h400; bus.exc_in_delay_slot = 1'b1;
      rst_n = 1'b0;
      tick();
      chk("rst2_status", bus.status, 32'h10000000);
      chk("rst2_cause",  bus.cause,  32'h0);
      chk("rst2_epc",    bus.epc,    32'h0);
      chk("rst2_count",  bus.count,  32'h0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/coprocessor0.md
COPROCESSOR0 -- requirements
Module: coprocessor0

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 32, giving the width of all data ports.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 we  input  1  software write enable (MTC0 retiring in writeback).
REQ-005 waddr  input  5  CP0 write register address.
REQ-006 wdata  input  DATA_WIDTH  CP0 write data.
REQ-007 raddr  input  5  CP0 read register address (MFC0).
REQ-008 rdata  output  DATA_WIDTH  CP0 read data.
REQ-009 int_i  input  6  external hardware interrupt lines, level-sensitive.
REQ-010 exc_valid  input  1  exception committed this cycle.
REQ-011 exc_code  input  5  ExcCode of the committed exception.
REQ-012 exc_pc  input  DATA_WIDTH  PC of the faulting instruction.
REQ-013 exc_in_delay_slot  input  1  faulting instruction is in a branch delay slot.
REQ-014 eret  input  1  ERET committed this cycle.
REQ-015 status, cause, epc, count, compare  output  DATA_WIDTH each  current register values.
REQ-016 timer_int  output  1  pending timer interrupt.

Function
REQ-017 Register addresses SHALL be COUNT=9, COMPARE=11, STATUS=12, CAUSE=13, EPC=14, PRID=15; other addresses SHALL read 0 and ignore writes.
REQ-018 count SHALL increment by 1 every cycle, wrapping 0xFFFFFFFF->0; a software write to COUNT SHALL load wdata instead of incrementing that cycle.
REQ-019 timer_int SHALL set on the cycle after count==compare with compare!=0, stay set, and clear on the cycle after any write to COMPARE.
REQ-020 status writable bits SHALL be [15:8] IM, [1] EXL, [0] IE; all other bits SHALL hold their reset value.
REQ-021 cause writable bits SHALL be [9:8] only; cause[15:10] SHALL be registered each cycle from {timer_int | int_i[5], int_i[4:0]}.
REQ-022 EPC SHALL be fully writable by software.
REQ-023 On exc_valid with status[1]=0: epc <= exc_in_delay_slot ? exc_pc-4 : exc_pc; cause[31] <= exc_in_delay_slot; cause[6:2] <= exc_code; status[1] <= 1.
REQ-024 On exc_valid with status[1]=1: only cause[6:2] SHALL update; epc and cause[31] SHALL hold.
REQ-025 On eret (no exc_valid): status[1] <= 0.
REQ-026 Priority within a cycle: exc_valid > eret > software write for any bit touched by more than one; untouched fields still take the software write.
REQ-027 rdata SHALL be combinational; when we and waddr==raddr, rdata SHALL return the post-write value of the writable bits (write-first bypass).
REQ-028 PRID SHALL read the constant 0x00004220.
REQ-029 All register outputs SHALL update only on rising clk; latency from we/exc_valid/eret to output is one cycle.

Reset
REQ-030 While rst_n=0 at a rising edge: status=0x10000000, cause=0, epc=0, count=0, compare=0, timer_int=0.
REQ-031 Reset SHALL override exc_valid, eret and we in the same cycle.
REQ-032 Reset asserted mid-exception SHALL leave no partial update.

Structure
REQ-033 Register addresses, ExcCode constants, PRID value and status/cause bit positions SHALL live in the shared defines file beside CP0_REG_BUS and DATA_BUS.
REQ-034 A sub-module cp0_timer SHALL hold count, compare and timer_int; everything else stays in coprocessor0.

Verification
REQ-035 Reset, then 5 idle cycles -> count=5, status=0x10000000, cause=0, timer_int=0.
REQ-036 Write COMPARE=20 at count=10 -> timer_int=1 the cycle after count==20; write COMPARE=40 -> timer_int=0 the next cycle.
REQ-037 exc_valid, exc_code=12, exc_pc=0x00400010, delay slot=1 -> epc=0x0040000C, cause[31]=1, cause[6:2]=12, status[1]=1.
REQ-038 Second exc_valid (exc_code=4, pc=0x00400100) while EXL=1 -> epc unchanged at 0x0040000C, cause[6:2]=4; then eret -> status[1]=0.
REQ-039 Write STATUS=0xFFFFFFFF -> status=0x1000FF03; write CAUSE=0xFFFFFFFF -> only cause[9:8]=2'b11 change; same-cycle MFC0 of STATUS returns 0x1000FF03.
REQ-040 we to EPC=0x1234 in the same cycle as exc_valid (pc=0x80, EXL=0) -> epc=0x80.
